// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Data-memory bus seen by the load/store unit: a single request/grant/rvalid
// transaction with byte enables.
//
// Signals (direction as seen from the LSU, i.e. the master):
//   data_req_o    out  bus request
//   data_gnt_i    in   bus grant
//   data_addr_o   out  word-aligned byte address
//   data_we_o     out  write enable
//   data_be_o     out  byte enables (one per byte lane)
//   data_wdata_o  out  lane-replicated store data
//   data_rvalid_i in   response valid (loads and stores)
//   data_err_i    in   response error, qualified by data_rvalid_i
//   data_rdata_i  in   read data, qualified by data_rvalid_i
//
// Modports: master (LSU side), slave (memory side).
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic [ADDR_WIDTH-1:0] data_addr_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [DATA_WIDTH-1:0] data_wdata_o;
    logic                  data_rvalid_i;
    logic                  data_err_i;
    logic [DATA_WIDTH-1:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Accepts one load or store from the execute stage, issues it as a single
// request/grant/rvalid transaction on the data bus and, for loads, returns the
// extracted and sign/zero-extended value to the register-file write mux.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   lsu_req_i           access request, sampled only while idle
//   lsu_we_i            1 = store, 0 = load
//   lsu_type_i          00 byte, 01 half, 10/11 word
//   lsu_sign_ext_i      loads: 1 = sign-extend, 0 = zero-extend
//   lsu_addr_i          byte address (ALU result)
//   lsu_wdata_i         store data (rs2)
//   lsu_busy_o          stall to the core
//   lsu_valid_o         one-cycle completion pulse
//   lsu_err_o           qualifies lsu_valid_o: bus or alignment error
//   lsu_rdata_o         extended load data, held until the next good load
//   bus                 data bus (load_store_unit_if.master)
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses without touching the bus (completes with lsu_err_o = 1).
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_type_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_valid_o,
    output logic                  lsu_err_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    load_store_unit_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_we;
    logic [1:0]            r_type;
    logic                  r_sext;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_latch;
    logic                  w_misal;
    logic                  w_busy;
    logic                  w_req;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_resp;

    function automatic logic [3:0] f_be(input logic [1:0] typ, input logic [1:0] a);
        case (typ)
            2'b00:   f_be = 4'b0001 << a;
            2'b01:   f_be = a[1] ? 4'b1100 : 4'b0011;
            default: f_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_wdata(input logic [1:0] typ,
                                                      input logic [DATA_WIDTH-1:0] w);
        case (typ)
            2'b00:   f_wdata = {(DATA_WIDTH/8){w[7:0]}};
            2'b01:   f_wdata = {(DATA_WIDTH/16){w[15:0]}};
            default: f_wdata = w;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_load(input logic [1:0] typ,
                                                     input logic sext,
                                                     input logic [1:0] a,
                                                     input logic [DATA_WIDTH-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (typ)
            2'b00:   f_load = {{(DATA_WIDTH-8){sext & b[7]}}, b};
            2'b01:   f_load = {{(DATA_WIDTH-16){sext & h[15]}}, h};
            default: f_load = rd;
        endcase
    endfunction

    // Response is only meaningful while waiting; anything else (late or
    // spurious rvalid) is dropped.
    assign w_resp = (r_state == S_WAIT) && bus.data_rvalid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_misal     = 1'b0;
        w_busy      = 1'b0;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_be        = 4'b0000;
        w_wdata     = '0;
        // While reset is held every output stays cleared, even if the core
        // is already presenting a request.
        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    if (lsu_req_i) begin
                        w_latch = 1'b1;
                        w_busy  = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        w_misal = ((lsu_type_i == 2'b01) && lsu_addr_i[0]) ||
                                  (lsu_type_i[1] && (lsu_addr_i[1:0] != 2'b00));
`endif
                        if (w_misal) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            // First request cycle is driven straight from the
                            // core so a zero-wait grant costs no extra cycle.
                            w_req       = 1'b1;
                            w_we        = lsu_we_i;
                            w_addr      = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            w_be        = f_be(lsu_type_i, lsu_addr_i[1:0]);
                            w_wdata     = f_wdata(lsu_type_i, lsu_wdata_i);
                            w_state_nxt = bus.data_gnt_i ? S_WAIT : S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    w_busy  = 1'b1;
                    w_req   = 1'b1;
                    w_we    = r_we;
                    w_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                    w_be    = f_be(r_type, r_addr[1:0]);
                    w_wdata = f_wdata(r_type, r_wdata);
                    if (bus.data_gnt_i) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    w_busy = 1'b1;
                    if (bus.data_rvalid_i) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_type  <= 2'b00;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_we    <= lsu_we_i;
                r_type  <= lsu_type_i;
                r_sext  <= lsu_sign_ext_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
                r_err   <= w_misal;
            end else if (w_resp) begin
                r_err <= bus.data_err_i;
                if (!r_we && !bus.data_err_i) begin
                    r_rdata <= f_load(r_type, r_sext, r_addr[1:0], bus.data_rdata_i);
                end
            end
        end
    end

    assign lsu_busy_o       = w_busy;
    assign lsu_valid_o      = (r_state == S_DONE);
    assign lsu_err_o        = (r_state == S_DONE) && r_err;
    assign lsu_rdata_o      = r_rdata;

    assign bus.data_req_o   = w_req;
    assign bus.data_we_o    = w_we;
    assign bus.data_addr_o  = w_addr;
    assign bus.data_be_o    = w_be;
    assign bus.data_wdata_o = w_wdata;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core datapath and the data-memory bus. It accepts one load or store per request from the execute stage, using the ALU result as address and the rs2 value as store data. It issues a single request/grant/rvalid transaction on the data bus with byte enables and lane-replicated write data. For loads, it extracts, sign- or zero-extends and returns the read value to the register-file write-port mux.

## Interface
- DATA_WIDTH, 32, data bus and register width
- ADDR_WIDTH, 32, address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- lsu_req_i  in  1  core requests an access; sampled only in IDLE
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- lsu_sign_ext_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- lsu_addr_i  in  ADDR_WIDTH  byte address (ALU result)
- lsu_wdata_i  in  DATA_WIDTH  store data (rs2)
- lsu_busy_o  out  1  stall the core; reset 0
- lsu_valid_o  out  1  one-cycle completion pulse; reset 0
- lsu_err_o  out  1  qualifies lsu_valid_o: bus or alignment error; reset 0
- lsu_rdata_o  out  DATA_WIDTH  extended load data, held until next load completes; reset 0
- data_req_o  out  1  bus request; reset 0
- data_gnt_i  in  1  bus grant
- data_addr_o  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2],2'b00}; reset 0
- data_we_o  out  1  write enable; reset 0
- data_be_o  out  4  byte enables; reset 0
- data_wdata_o  out  DATA_WIDTH  lane-replicated store data; reset 0
- data_rvalid_i  in  1  response valid (loads and stores)
- data_err_i  in  1  response error, qualified by data_rvalid_i
- data_rdata_i  in  DATA_WIDTH  read data, qualified by data_rvalid_i

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE:** on lsu_req_i, latch we, type, sign_ext, addr and wdata.
  - Drive data_req_o and the bus fields combinationally from the inputs in the same cycle.
  - If data_gnt_i is also high, go to WAIT; otherwise go to REQ.
- **REQ:** hold data_req_o and all bus fields, taken from the latched values, stable until data_gnt_i is high, then go to WAIT.
- **WAIT:** data_req_o = 0. On data_rvalid_i:
  - Load with data_err_i = 0: capture the extended data into lsu_rdata_o.
  - Store, or data_err_i = 1: lsu_rdata_o is unchanged.
  - Register the error flag, then go to DONE.
- **DONE:** lsu_valid_o = 1 and lsu_err_o = the registered flag, for one cycle. Then return to IDLE.
- lsu_busy_o = (state != IDLE) | (state == IDLE & lsu_req_i). It drops in the DONE cycle.
- **Byte enables:**
  - Byte: 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- **Store data:**
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- **Load extraction:**
  - Byte: data_rdata_i[8*addr[1:0] +: 8].
  - Half: data_rdata_i[16*addr[1] +: 16].
  - The result is extended to DATA_WIDTH according to the latched sign_ext.
- **Reset mid-operation:** all state goes to IDLE and all outputs are cleared immediately.
  - Any outstanding bus transaction is abandoned, and a late rvalid is ignored in IDLE.
  - data_rvalid_i is ignored in any state other than WAIT.

## Timing
- Zero-wait-state bus: gnt in the request cycle (T0) and rvalid at T1.
  - lsu_valid_o at T2.
  - lsu_busy_o is high in T0 and T1.
- Each gnt stall adds one cycle in REQ. Each cycle of rvalid latency adds one cycle in WAIT.
- One outstanding transaction at most. A new request is accepted only in IDLE, earliest the cycle after DONE.
- lsu_rdata_o changes on the clock edge that enters DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no bus request. data_req_o stays 0.
  - The FSM goes IDLE -> DONE, giving lsu_valid_o = 1 and lsu_err_o = 1 in the next cycle.
  - lsu_rdata_o is unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - No alignment check is made.
  - Half accesses use addr[1] only, and word accesses use the aligned word.
  - lsu_err_o reflects data_err_i only.

## Test plan
- **Word load, zero-wait:** addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> data_addr_o 0x100, be 1111, lsu_valid_o at T2, lsu_rdata_o 0xDEADBEEF, err 0.
- **Signed byte load:** addr 0x103, rdata 0x80FF_0000 -> be 1000, lsu_rdata_o 0xFFFFFF80. Same access with sign_ext = 0 -> 0x00000080.
- **Half store with gnt stall:** addr 0x202, wdata 0x1234ABCD, gnt after 3 cycles -> data_req_o and fields stable for 4 cycles, data_addr_o 0x200, be 1100, data_wdata_o 0xABCDABCD, lsu_busy_o high until DONE.
- **Bus error on load:** rvalid with data_err_i = 1 -> lsu_valid_o and lsu_err_o pulse together, lsu_rdata_o keeps its previous value.
- **Misaligned word load to 0x101:**
  - With LSU_MISALIGN_TRAP_EN: no data_req_o, err pulse after 1 cycle.
  - Without it: request to 0x100, be 1111.
- **Reset asserted in WAIT:** outputs go to 0 immediately. A late rvalid after reset release produces no lsu_valid_o.
